// File: rtl/addsub_pkg.sv
// Shared width and word type for the mantissa add/sub datapath.
package addsub_pkg;

  localparam int ADDSUB_W = 24;

  typedef logic [ADDSUB_W-1:0] word_t;

endpackage : addsub_pkg

// File: rtl/full_adder.sv
// One-bit full adder; the ripple-carry chain is built from these.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder

// File: rtl/addsub_24bit.sv
// Registered two's-complement adder/subtractor: c_in=0 adds, c_in=1 subtracts
// as A + ~B + 1. Sum and carry-out are registered (one-cycle latency).
module addsub_24bit
  import addsub_pkg::*;
#(
  parameter int N = ADDSUB_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         c_in,
  output logic [N-1:0] S,
  output logic         c_out
);

  logic [N-1:0] w_b_mod;
  logic [N-1:0] w_sum;
  logic [N:0]   w_carry;

  logic [N-1:0] r_s;
  logic         r_c_out;

  // c_in doubles as the inversion select and the +1 of the two's complement.
  assign w_b_mod    = B ^ {N{c_in}};
  assign w_carry[0] = c_in;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ripple
      full_adder u_fa (
        .a    (A[gi]),
        .b    (w_b_mod[gi]),
        .cin  (w_carry[gi]),
        .s    (w_sum[gi]),
        .cout (w_carry[gi+1])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s     <= '0;
      r_c_out <= 1'b0;
    end else begin
      r_s     <= w_sum;
      r_c_out <= w_carry[N];
    end
  end

  assign S     = r_s;
  assign c_out = r_c_out;

endmodule : addsub_24bit

// File: tb/tb_addsub_24bit.sv
// Scoreboard bench for addsub_24bit: driver queues expected results, monitor
// compares one cycle later.
module tb_addsub_24bit;

  localparam int W = 24;

  logic         clk;
  logic         rst;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         c_in;
  logic [W-1:0] S;
  logic         c_out;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  bit   drive_done = 0;

  addsub_24bit #(.N(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .c_in  (c_in),
    .S     (S),
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic. Add carry is sum >= 2^W;
  // subtract carry is "no borrow", i.e. A >= B unsigned.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic r, input string nm);
    exp_t e;
    longint unsigned ua, ub, tot;
    ua = longint'(a);
    ub = longint'(b);
    e.name = nm;
    if (r) begin
      e.s = '0;
      e.c = 1'b0;
    end else if (!ci) begin
      tot = ua + ub;
      e.s = W'(tot % (64'd1 << W));
      e.c = (tot >= (64'd1 << W));
    end else begin
      tot = (ua + (64'd1 << W) - ub) % (64'd1 << W);
      e.s = W'(tot);
      e.c = (ua >= ub);
    end
    return e;
  endfunction

  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic r, input string nm);
    @(negedge clk);
    A    = a;
    B    = b;
    c_in = ci;
    rst  = r;
    exp_q.push_back(model(a, b, ci, r, nm));
  endtask

  function automatic logic [W-1:0] sext8(input logic [7:0] v);
    return {{(W-8){v[7]}}, v};
  endfunction

  // Monitor: every edge produces a result; compare against the oldest entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests_run++;
        if (S !== e.s || c_out !== e.c) begin
          tests_failed++;
          $display("[TB] FAIL %s: got S=%06h c_out=%b, expected S=%06h c_out=%b",
                   e.name, S, c_out, e.s, e.c);
        end else begin
          $display("[TB] ok   %s: S=%06h c_out=%b", e.name, S, c_out);
        end
      end
    end
  end

  // Driver.
  initial begin
    logic [7:0] ra, rb;
    rst  = 1'b1;
    A    = '0;
    B    = '0;
    c_in = 1'b0;

    apply(W'($urandom), W'($urandom), 1'b0, 1'b1, "reset0");
    apply(W'($urandom), W'($urandom), 1'b1, 1'b1, "reset1");
    apply(24'd5, 24'd10, 1'b0, 1'b0, "first_after_reset");

    apply(24'd30,       24'hFFFFF6, 1'b0, 1'b0, "add_wrap_neg10");
    apply(24'd127,      24'hFFFFFF, 1'b0, 1'b0, "add_wrap_neg1");
    apply(24'd5,        24'd10,     1'b1, 1'b0, "sub_borrow");
    apply(24'd10,       24'd10,     1'b1, 1'b0, "sub_equal");
    apply(24'hFFFFFF,   24'd1,      1'b0, 1'b0, "add_max_plus1");
    apply(24'd0,        24'd0,      1'b1, 1'b0, "sub_zero_zero");
    apply(24'h800000,   24'd1,      1'b1, 1'b0, "sub_min_minus1");
    apply(24'h123456,   24'h654321, 1'b0, 1'b0, "add_plain");

    // Back-to-back stream with reset in the middle.
    for (int i = 0; i < 8; i++) begin
      apply(W'($urandom), W'($urandom), 1'($urandom), (i == 4) ? 1'b1 : 1'b0,
            (i == 4) ? "stream_reset" : "stream");
    end
    apply(24'd7, 24'd3, 1'b1, 1'b0, "after_mid_reset");

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      apply(sext8(ra), sext8(rb), 1'($urandom), 1'b0, "random");
    end

    // Drain: allow the last result to be checked, bounded wait.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    drive_done = 1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog against a stalled simulation.
  initial begin
    #200000;
    if (!drive_done) begin
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "timeout");
    end
  end

endmodule : tb_addsub_24bit
